alu_op_responder: RTL and testbench
===================================

Name: alu_op_responder

Overview:
- Sequential request/response front end for the 8-bit ALU datapath.
- Accepts one operation request (opA, opB, opcode) over a valid/ready handshake and executes it.
- Single-cycle ops take one execute cycle; MUL runs as an 8-cycle shift-add.
- Returns result and flags over a second valid/ready handshake. It is the responder that testbenches and upstream controllers drive in place of calling ADD/SUB directly.

Parameters:
- WIDTH, 8, operand and result width.
- MUL_CYCLES, WIDTH, iterations of the shift-add multiplier; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal.
- req_opA  input  WIDTH  operand A.
- req_opB  input  WIDTH  operand B.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  result; low WIDTH bits for MUL.
- rsp_hi  output  WIDTH  high WIDTH bits of the MUL product; 0 for all other ops.
- rsp_carry  output  1  ADD carry out; SUB borrow (opA<opB unsigned); 0 otherwise.
- rsp_zero  output  1  rsp_result == 0.
- rsp_ovf  output  1  signed overflow for ADD/SUB; for MUL, rsp_hi != 0.
- rsp_err  output  1  illegal opcode.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; the operation in progress or the pending response is discarded.
  - req_ready=1, rsp_valid=0; all rsp_* data and flag outputs = 0.
  - Internal accumulator and counter cleared.
- States: IDLE, EXEC, MULT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid && req_ready at an edge: latch opcode and operands. Go to MULT if opcode==5, else EXEC.
- EXEC, one cycle:
  - Compute the result with a WIDTH+1-bit add/sub; register it with flags; go to RESP.
  - SUB computes opA + ~opB + 1; carry = NOT bit WIDTH of that sum (borrow).
  - Signed overflow: ADD sets it when operand signs match and the result sign differs. SUB sets it when operand signs differ and the result sign differs from opA.
  - Illegal opcode: result=0, zero=1, err=1, other flags 0.
- MULT:
  - 2*WIDTH-bit accumulator and 4-bit counter. Each cycle, if multiplier LSB=1 add the shifted multiplicand; shift.
  - After MUL_CYCLES cycles go to RESP. rsp_result = product[WIDTH-1:0], rsp_hi = product[2*WIDTH-1:WIDTH].
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_* outputs are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready at an edge: rsp_valid falls and state returns to IDLE. No same-edge re-accept; the next request is accepted one cycle later.
- Latency, measured from the req accept edge to the first cycle rsp_valid=1:
  - single-cycle ops: 2 edges.
  - MUL: 1 + MUL_CYCLES edges = 9.
- req_ready=0 in EXEC, MULT and RESP. req_* inputs are ignored there, and no request is ever dropped while req_ready=1.
- Arithmetic wraps modulo 2^WIDTH: 255+1 gives 0, carry=1, zero=1. 0-1 gives 255, carry=1.
- Reset asserted in MULT or RESP aborts the operation; no response is produced.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_MUL;
  - state encoding constants;
  - WIDTH default.
- One sub-module, alu_shift_add_mul: start/done handshake, holds accumulator and counter. Instantiated by the responder for MULT.
- ADD/SUB/logic ops stay inline in EXEC.

Test Plan:
- SUB 15,3 → 2 edges after accept: rsp_valid=1, result=12, carry=0, zero=0, ovf=0.
- SUB 3,15 → result=244, carry=1. ADD 127,1 → result=128, ovf=1. ADD 255,1 → result=0, carry=1, zero=1.
- MUL 15,17 → rsp_valid exactly 9 edges after accept, result=255, hi=0, ovf=0. MUL 200,200 → result=64, hi=156, ovf=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after XOR 0xAA,0x0F → rsp_result=0xA5 stable, req_ready=0 throughout. Assert rsp_ready → IDLE, req_ready=1 the next cycle.
- Opcode 7 with opA=9, opB=9 → err=1, result=0, zero=1.
- Reset asserted during MULT cycle 4 → next cycle: rsp_valid=0, req_ready=1, all outputs 0. A following ADD 1,2 returns 3 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU request/response front end.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Shift-add multiplier: start loads operands, MUL_CYCLES iterations follow.
// done is high during the final iteration; product then already includes that iteration.
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [3:0]         cnt_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc_q;
    if (mplier_q[0]) acc_nxt = acc_q + mcand_q;
  end

  assign done    = busy_q && (cnt_q == 4'(MUL_CYCLES - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mcand};
      mplier_q <= mplier;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 4'd1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_responder.sv
// Request/response ALU front end: 2-edge latency for single-cycle ops, 1+MUL_CYCLES for MUL.
// One operation in flight; req_ready low until the response is taken, outputs held under rsp backpressure.
module alu_op_responder
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_opcode,
  input  logic [WIDTH-1:0] req_opA,
  input  logic [WIDTH-1:0] req_opB,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic               accept;
  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               is_sub;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_carry, ex_ovf, ex_err;

  assign accept    = req_valid && req_ready;
  assign mul_start = accept && (req_opcode == OP_MUL);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (req_opcode == OP_MUL) ? ST_MULT : ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_MULT: if (mul_done) state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      op_q  <= req_opcode;
      opa_q <= req_opA;
      opb_q <= req_opB;
    end
  end

  // SUB reuses the adder as opA + ~opB + 1; bit WIDTH is then the inverted borrow.
  always_comb begin
    is_sub   = (op_q == OP_SUB);
    sum      = {1'b0, opa_q} + {1'b0, (is_sub ? ~opb_q : opb_q)} + {{WIDTH{1'b0}}, is_sub};
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    ex_err   = 1'b0;
    case (op_q)
      OP_ADD: begin
        ex_res   = sum[WIDTH-1:0];
        ex_carry = sum[WIDTH];
        ex_ovf   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (ex_res[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_res   = sum[WIDTH-1:0];
        ex_carry = ~sum[WIDTH];
        ex_ovf   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) && (ex_res[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OP_AND:  ex_res = opa_q & opb_q;
      OP_OR:   ex_res = opa_q | opb_q;
      OP_XOR:  ex_res = opa_q ^ opb_q;
      default: ex_err = 1'b1;
    endcase
  end

  alu_shift_add_mul #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   (req_opA),
    .mplier  (req_opB),
    .done    (mul_done),
    .product (mul_product)
  );

  // Response registers only load on completion, so they stay put while RESP waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_hi     <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_result <= ex_res;
      rsp_hi     <= '0;
      rsp_carry  <= ex_carry;
      rsp_zero   <= (ex_res == '0);
      rsp_ovf    <= ex_ovf;
      rsp_err    <= ex_err;
    end else if ((state_q == ST_MULT) && mul_done) begin
      rsp_result <= mul_product[WIDTH-1:0];
      rsp_hi     <= mul_product[2*WIDTH-1:WIDTH];
      rsp_carry  <= 1'b0;
      rsp_zero   <= (mul_product[WIDTH-1:0] == '0);
      rsp_ovf    <= (mul_product[2*WIDTH-1:WIDTH] != '0);
      rsp_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Self-checking bench for alu_op_responder: directed cases, backpressure, reset abort, random ops.
module tb_alu_op_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_opcode;
  logic [7:0] req_opA, req_opB;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result, rsp_hi;
  logic       rsp_carry, rsp_zero, rsp_ovf, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       v;
    logic       e;
  } exp_t;

  alu_op_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_opA    (req_opA),
    .req_opB    (req_opB),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_hi     (rsp_hi),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int to_signed8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int r, s, p;
    e = '0;
    r = 0;
    case (op)
      0: begin
        r   = (a + b) % 256;
        e.c = (a + b) > 255;
        s   = to_signed8(a) + to_signed8(b);
        e.v = (s > 127) || (s < -128);
      end
      1: begin
        r   = (a - b + 256) % 256;
        e.c = a < b;
        s   = to_signed8(a) - to_signed8(b);
        e.v = (s > 127) || (s < -128);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        p    = a * b;
        r    = p % 256;
        e.hi = 8'(p / 256);
        e.v  = (p / 256) != 0;
      end
      default: e.e = 1'b1;
    endcase
    e.res = 8'(r);
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic check_rsp(input string tag, input exp_t e);
    chk({tag, ".result"}, 32'(rsp_result), 32'(e.res));
    chk({tag, ".hi"},     32'(rsp_hi),     32'(e.hi));
    chk({tag, ".carry"},  32'(rsp_carry),  32'(e.c));
    chk({tag, ".zero"},   32'(rsp_zero),   32'(e.z));
    chk({tag, ".ovf"},    32'(rsp_ovf),    32'(e.v));
    chk({tag, ".err"},    32'(rsp_err),    32'(e.e));
  endtask

  // Issue one request, check latency, hold rsp_ready low for 'stall' cycles, then complete.
  task automatic do_op(input string tag, input int op, input int a, input int b, input int stall);
    exp_t e;
    int   lat;
    e = model(op, a, b);
    chk({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_opcode = 3'(op);
    req_opA    = 8'(a);
    req_opB    = 8'(b);
    @(posedge clk); #1;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      req_valid  = 1'($urandom);
      req_opcode = 3'($urandom);
      req_opA    = 8'($urandom);
      req_opB    = 8'($urandom);
      chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (op == 5) ? 32'd9 : 32'd2);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'($urandom);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".hold_result"}, 32'(rsp_result), 32'(e.res));
      @(posedge clk); #1;
    end
    check_rsp(tag, e);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, ".valid_after"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_opA    = '0;
    req_opB    = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check_rsp("reset", '0);
    rst = 1'b0;

    do_op("sub15_3",   1, 15, 3, 0);
    do_op("sub3_15",   1, 3, 15, 0);
    do_op("add127_1",  0, 127, 1, 0);
    do_op("add255_1",  0, 255, 1, 0);
    do_op("sub0_1",    1, 0, 1, 0);
    do_op("mul15_17",  5, 15, 17, 0);
    do_op("mul200_200", 5, 200, 200, 0);
    do_op("xor_bp",    4, 8'hAA, 8'h0F, 5);
    do_op("illegal7",  7, 9, 9, 0);
    do_op("and",       2, 8'hF0, 8'h3C, 1);
    do_op("or",        3, 8'h00, 8'h00, 0);

    // Reset during the 4th MULT cycle discards the operation.
    req_valid  = 1'b1;
    req_opcode = 3'd5;
    req_opA    = 8'd200;
    req_opB    = 8'd201;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    check_rsp("abort", '0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort.no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op("add1_2", 0, 1, 2, 0);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
